// File: rtl/cpu_md_pkg.sv
// Shared encodings for the MEM-stage multiply/divide unit.
package cpu_md_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_MADD  = 3'b110,
    MD_MADDU = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Per-operation flags latched at start and consumed in FIX.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic madd;
  } md_ctl_t;

endpackage

// File: rtl/cpu_mem_muldiv_if.sv
// MEM-stage request / HI-LO result bundle between the pipeline and the md unit.
interface cpu_mem_muldiv_if
  import cpu_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32
);
  logic              md_start;
  md_op_e            md_op;
  logic [DATA_W-1:0] md_rs;
  logic [DATA_W-1:0] md_rt;
  logic              md_flush;
  logic              md_busy;
  logic              md_done;
  logic [DATA_W-1:0] m_mul_hi;
  logic [DATA_W-1:0] m_mul_lo;

  modport master (
    output md_start, md_op, md_rs, md_rt, md_flush,
    input  md_busy, md_done, m_mul_hi, m_mul_lo
  );

  modport slave (
    input  md_start, md_op, md_rs, md_rt, md_flush,
    output md_busy, md_done, m_mul_hi, m_mul_lo
  );
endinterface

// File: rtl/cpu_md_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module cpu_md_divstep
  import cpu_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0] shifted_c;
  logic            ge_c;

  assign shifted_c = {rem_i, quo_i[DATA_W-1]};
  assign ge_c      = (shifted_c >= {1'b0, div_i});
  // When the subtract is taken the true difference is below 2**DATA_W, so wrapping is exact.
  assign rem_o     = ge_c ? (shifted_c[DATA_W-1:0] - div_i) : shifted_c[DATA_W-1:0];
  assign quo_o     = {quo_i[DATA_W-2:0], ge_c};

endmodule

// File: rtl/cpu_mem_muldiv.sv
// Iterative MULT/DIV unit owning HI/LO; 33-cycle busy window per mul/div op.
// Define CPU_MD_MADD_EN to enable MADD/MADDU (op 110/111) accumulation into HI/LO.
module cpu_mem_muldiv
  import cpu_md_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 5
) (
  input logic             clk,
  input logic             rst,
  cpu_mem_muldiv_if.slave md
);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  md_ctl_t           ctl_q, ctl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              op_mul_c, op_div_c, op_madd_c, op_sgn_c;
  logic              rs_neg_c, rt_neg_c, rt_zero_c;
  logic [DATA_W:0]   mul_sum_c;
  logic [DATA_W-1:0] div_rem_c, div_quo_c;
  logic [DATA_W-1:0] quo_res_c, rem_res_c;
  logic [2*DATA_W-1:0] prod_sgn_c, acc_sum_c;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

`ifdef CPU_MD_MADD_EN
  assign op_madd_c = (md.md_op == MD_MADD) || (md.md_op == MD_MADDU);
`else
  assign op_madd_c = 1'b0;
`endif
  assign op_mul_c  = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU) || op_madd_c;
  assign op_div_c  = (md.md_op == MD_DIV) || (md.md_op == MD_DIVU);
  assign op_sgn_c  = (md.md_op == MD_MULT) || (md.md_op == MD_DIV) || (md.md_op == MD_MADD);
  assign rs_neg_c  = op_sgn_c & md.md_rs[DATA_W-1];
  assign rt_neg_c  = op_sgn_c & md.md_rt[DATA_W-1];
  assign rt_zero_c = (md.md_rt == '0);

  // Shift-add multiply step: {a,b} holds {partial product, remaining multiplier}.
  assign mul_sum_c = {1'b0, a_q} + ({1'b0, m_q} & {(DATA_W+1){b_q[0]}});

  cpu_md_divstep #(.DATA_W(DATA_W)) u_divstep (
    .rem_i (a_q),
    .quo_i (b_q),
    .div_i (m_q),
    .rem_o (div_rem_c),
    .quo_o (div_quo_c)
  );

  assign prod_sgn_c = ctl_q.neg_res ? -{a_q, b_q} : {a_q, b_q};
  assign acc_sum_c  = {hi_q, lo_q} + prod_sgn_c;
  assign quo_res_c  = ctl_q.neg_res ? -b_q : b_q;
  assign rem_res_c  = ctl_q.neg_rem ? -a_q : a_q;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ctl_d   = ctl_q;
    done_d  = 1'b0;

    unique case (state_q)
      MD_IDLE: begin
        if (md.md_start && !md.md_flush) begin
          if (md.md_op == MD_MTHI) begin
            hi_d = md.md_rs;
          end else if (md.md_op == MD_MTLO) begin
            lo_d = md.md_rs;
          end else if (op_mul_c || op_div_c) begin
            state_d       = MD_CALC;
            cnt_d         = '0;
            a_d           = '0;
            m_d           = op_mul_c ? mag(md.md_rs, rs_neg_c) : mag(md.md_rt, rt_neg_c);
            b_d           = op_mul_c ? mag(md.md_rt, rt_neg_c) : mag(md.md_rs, rs_neg_c);
            ctl_d.is_div  = op_div_c;
            ctl_d.madd    = op_madd_c;
            // Divide-by-zero keeps an all-ones quotient regardless of operand signs.
            ctl_d.neg_res = (rs_neg_c ^ rt_neg_c) & ~(op_div_c & rt_zero_c);
            ctl_d.neg_rem = rs_neg_c;
          end
        end
      end
      MD_CALC: begin
        if (md.md_flush) begin
          state_d = MD_IDLE;
        end else begin
          if (ctl_q.is_div) begin
            a_d = div_rem_c;
            b_d = div_quo_c;
          end else begin
            {a_d, b_d} = {mul_sum_c, b_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MD_ITER - 1)) begin
            state_d = MD_FIX;
          end
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!md.md_flush) begin
          done_d = 1'b1;
          if (ctl_q.is_div) begin
            hi_d = rem_res_c;
            lo_d = quo_res_c;
          end else if (ctl_q.madd) begin
            {hi_d, lo_d} = acc_sum_c;
          end else begin
            {hi_d, lo_d} = prod_sgn_c;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d != MD_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ctl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ctl_q   <= ctl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign md.md_busy  = busy_q;
  assign md.md_done  = done_q;
  assign md.m_mul_hi = hi_q;
  assign md.m_mul_lo = lo_q;

endmodule

// File: tb/tb_cpu_mem_muldiv.sv
// Self-checking bench for cpu_mem_muldiv: directed cases plus randomized traffic vs. an arithmetic model.
module tb_cpu_mem_muldiv;
  import cpu_md_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT = 33;

  logic clk = 1'b0;
  logic rst;

  cpu_mem_muldiv_if #(.DATA_W(W)) md_if ();

  cpu_mem_muldiv #(.DATA_W(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference state: committed HI/LO, cycles left in the current op, and its pending result.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;
  bit          m_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mul/div/madd op, straight from the arithmetic definition.
  function automatic void md_result(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                    input logic [31:0] hi0, input logic [31:0] lo0,
                                    output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb;
    int          da, db;
    logic [63:0] p;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    da = $signed(rs);
    db = $signed(rt);
    hi = hi0;
    lo = lo0;
    case (op)
      3'b000: begin p = 64'(sa * sb); {hi, lo} = p; end
      3'b001: begin p = {32'h0, rs} * {32'h0, rt}; {hi, lo} = p; end
      3'b010, 3'b011: begin
        if (rt == 32'h0) begin
          lo = 32'hFFFF_FFFF;
          hi = rs;
        end else if (op == 3'b010 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else if (op == 3'b010) begin
          lo = 32'(da / db);
          hi = 32'(da % db);
        end else begin
          lo = rs / rt;
          hi = rs % rt;
        end
      end
      3'b110: begin p = 64'(sa * sb); {hi, lo} = {hi0, lo0} + p; end
      3'b111: begin p = {32'h0, rs} * {32'h0, rt}; {hi, lo} = {hi0, lo0} + p; end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [2:0] op;
    op = md_if.md_op;
    m_done = 1'b0;
    if (rst) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
      m_left = 0;
    end else if (m_left > 0) begin
      if (md_if.md_flush) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi;
          m_lo = p_lo;
          m_done = 1'b1;
        end
      end
    end else if (md_if.md_start && !md_if.md_flush) begin
      if (op == 3'b100) m_hi = md_if.md_rs;
      else if (op == 3'b101) m_lo = md_if.md_rs;
`ifdef CPU_MD_MADD_EN
      else begin
`else
      else if (op[2] == 1'b0) begin
`endif
        md_result(op, md_if.md_rs, md_if.md_rt, m_hi, m_lo, p_hi, p_lo);
        m_left = LAT;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(md_if.md_busy), 64'(m_left > 0));
      check("done", 64'(md_if.md_done), 64'(m_done));
      check("hi", 64'(md_if.m_mul_hi), 64'(m_hi));
      check("lo", 64'(md_if.m_mul_lo), 64'(m_lo));
    end
  end

  task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic fl);
    md_if.md_start = s;
    md_if.md_op    = md_op_e'(op);
    md_if.md_rs    = rs;
    md_if.md_rt    = rt;
    md_if.md_flush = fl;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    drive(1'b1, op, rs, rt, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 100 && md_if.md_busy; i++) begin
      cyc++;
      @(negedge clk);
    end
    if (md_if.md_busy) check("wait_idle_timeout", 64'(md_if.md_busy), 64'(0));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int cyc);
    issue(op, rs, rt);
    wait_idle(cyc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [31:0] hi_s, lo_s;
    rst = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_hi", 64'(md_if.m_mul_hi), 64'h0);
    check("rst_lo", 64'(md_if.m_mul_lo), 64'h0);
    check("rst_busy", 64'(md_if.md_busy), 64'h0);
    check("rst_done", 64'(md_if.md_done), 64'h0);
    rst = 1'b0;

    run_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, cyc);
    check("mult_latency", 64'(cyc), 64'(33));
    check("mult_done", 64'(md_if.md_done), 64'h1);
    check("mult_hi", 64'(md_if.m_mul_hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(md_if.m_mul_lo), 64'hFFFF_FFFA);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_hi", 64'(md_if.m_mul_hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(md_if.m_mul_lo), 64'h0000_0001);

    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, cyc);
    check("div_lo", 64'(md_if.m_mul_lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(md_if.m_mul_hi), 64'hFFFF_FFFF);

    run_op(3'b011, 32'h0000_0007, 32'h0, cyc);
    check("divu0_lo", 64'(md_if.m_mul_lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(md_if.m_mul_hi), 64'h7);

    run_op(3'b010, 32'hFFFF_FFF9, 32'h0, cyc);
    check("div0_neg_lo", 64'(md_if.m_mul_lo), 64'hFFFF_FFFF);
    check("div0_neg_hi", 64'(md_if.m_mul_hi), 64'hFFFF_FFF9);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("divovf_lo", 64'(md_if.m_mul_lo), 64'h8000_0000);
    check("divovf_hi", 64'(md_if.m_mul_hi), 64'h0);

    issue(3'b100, 32'h1234_5678, 32'h0);
    check("mthi_hi", 64'(md_if.m_mul_hi), 64'h1234_5678);
    check("mthi_busy", 64'(md_if.md_busy), 64'h0);
    check("mthi_done", 64'(md_if.md_done), 64'h0);

    issue(3'b010, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    md_if.md_flush = 1'b1;
    @(negedge clk);
    md_if.md_flush = 1'b0;
    check("flush_busy", 64'(md_if.md_busy), 64'h0);
    check("flush_hi", 64'(md_if.m_mul_hi), 64'h1234_5678);

    issue(3'b010, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    drive(1'b1, 3'b001, 32'd2, 32'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    wait_idle(cyc);
    check("busy_start_lo", 64'(md_if.m_mul_lo), 64'd14);
    check("busy_start_hi", 64'(md_if.m_mul_hi), 64'd2);
    @(negedge clk);
    check("busy_start_nobusy", 64'(md_if.md_busy), 64'h0);

    issue(3'b000, 32'd5, 32'd6);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_hi", 64'(md_if.m_mul_hi), 64'h0);
    check("midrst_lo", 64'(md_if.m_mul_lo), 64'h0);
    check("midrst_busy", 64'(md_if.md_busy), 64'h0);

    drive(1'b1, 3'b101, 32'hABCD_0000, 32'h0, 1'b1);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd9, 32'd9, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    check("flushstart_lo", 64'(md_if.m_mul_lo), 64'h0);
    check("flushstart_busy", 64'(md_if.md_busy), 64'h0);

`ifdef CPU_MD_MADD_EN
    issue(3'b100, 32'h0, 32'h0);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0);
    run_op(3'b111, 32'h1, 32'h1, cyc);
    check("maddu_hi", 64'(md_if.m_mul_hi), 64'h1);
    check("maddu_lo", 64'(md_if.m_mul_lo), 64'h0);
`else
    hi_s = md_if.m_mul_hi;
    lo_s = md_if.m_mul_lo;
    issue(3'b110, 32'h5, 32'h7);
    check("op110_busy", 64'(md_if.md_busy), 64'h0);
    @(negedge clk);
    check("op110_done", 64'(md_if.md_done), 64'h0);
    check("op110_hi", 64'(md_if.m_mul_hi), 64'(hi_s));
    check("op110_lo", 64'(md_if.m_mul_lo), 64'(lo_s));
`endif

    // Random traffic: starts while busy, flushes, occasional reset, all op codes.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 1999) == 0);
      drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), pick(), pick(),
            ($urandom_range(0, 63) == 0));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
